tdp_ram_dual: RTL and testbench

- True dual-port synchronous RAM: two independent read/write ports (A, B) sharing one storage array and one clock.
- Used as the record store behind the FIFO manager: port A is the push/write side, port B the pop/scan read side.
- Default geometry is 1024 x 48-bit records (6 bytes each).
- Registered read outputs with 1-cycle latency; the instantiating logic may drive clk with an inverted system clock.

---
 rtl/tdp_ram_dual.sv | 62 ++++++
 tb/tb_tdp_ram_dual.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tdp_ram_dual.sv
// True dual-port synchronous RAM, one clock, registered 1-cycle read outputs, port A wins write collisions.
// Optional macro TDP_RAM_WRITE_THROUGH_EN selects write-first outputs; default is read-first.
module tdp_ram_dual #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_a,
  input  logic              rnw_a,
  input  logic [ADDR_W-1:0] a_add,
  input  logic [DATA_W-1:0] a_data_in,
  output logic [DATA_W-1:0] a_data_out,
  input  logic              cs_b,
  input  logic              rnw_b,
  input  logic [ADDR_W-1:0] b_add,
  input  logic [DATA_W-1:0] b_data_in,
  output logic [DATA_W-1:0] b_data_out
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_a_wr;
  logic              w_b_wr;
  logic              w_same;
  logic              w_b_wr_eff;
  logic [DATA_W-1:0] w_a_next;
  logic [DATA_W-1:0] w_b_next;

  assign w_a_wr     = cs_a & ~rnw_a;
  assign w_b_wr     = cs_b & ~rnw_b;
  assign w_same     = (a_add == b_add);
  // Port B's write is discarded when A writes the same word on the same edge.
  assign w_b_wr_eff = w_b_wr & ~(w_a_wr & w_same);

`ifdef TDP_RAM_WRITE_THROUGH_EN
  // Each output shows what the addressed word holds after this edge.
  assign w_a_next = w_a_wr             ? a_data_in :
                    (w_b_wr & w_same)  ? b_data_in : r_mem[a_add];
  assign w_b_next = (w_a_wr & w_same)  ? a_data_in :
                    w_b_wr             ? b_data_in : r_mem[b_add];
`else
  assign w_a_next = r_mem[a_add];
  assign w_b_next = r_mem[b_add];
`endif

  // Array shares the reset process so that writes are suppressed while rst is high;
  // only the output registers are actually cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_data_out <= '0;
      b_data_out <= '0;
    end else begin
      if (w_a_wr)     r_mem[a_add] <= a_data_in;
      if (w_b_wr_eff) r_mem[b_add] <= b_data_in;
      if (cs_a)       a_data_out   <= w_a_next;
      if (cs_b)       b_data_out   <= w_b_next;
    end
  end

endmodule

// File: tb/tb_tdp_ram_dual.sv
// Scoreboard bench for tdp_ram_dual: stimulus queues per-port expectations, a monitor checks outputs each edge.
module tb_tdp_ram_dual;

  localparam int DW = 48;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cs_a = 1'b0, rnw_a = 1'b1, cs_b = 1'b0, rnw_b = 1'b1;
  logic [AW-1:0] a_add = '0, b_add = '0;
  logic [DW-1:0] a_data_in = '0, b_data_in = '0;
  logic [DW-1:0] a_data_out, b_data_out;

  tdp_ram_dual #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cs_a(cs_a), .rnw_a(rnw_a), .a_add(a_add), .a_data_in(a_data_in), .a_data_out(a_data_out),
    .cs_b(cs_b), .rnw_b(rnw_b), .b_add(b_add), .b_data_in(b_data_in), .b_data_out(b_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            chk;
    logic [DW-1:0] exp;
    string         name;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each rising edge consumes one queued expectation per port.
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      if (ea.chk) check(ea.name, a_data_out, ea.exp);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      if (eb.chk) check(eb.name, b_data_out, eb.exp);
    end
  end

  task automatic drive(input logic csa, input logic rnwa, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic csb, input logic rnwb, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    cs_a = csa; rnw_a = rnwa; a_add = aa; a_data_in = ad;
    cs_b = csb; rnw_b = rnwb; b_add = ba; b_data_in = bd;
  endtask

  task automatic cyc(input logic csa, input logic rnwa, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                     input bit ca, input logic [DW-1:0] xa,
                     input logic csb, input logic rnwb, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                     input bit cb, input logic [DW-1:0] xb, input string nm);
    exp_t e;
    @(negedge clk);
    drive(csa, rnwa, aa, ad, csb, rnwb, ba, bd);
    e.chk = ca; e.exp = xa; e.name = {nm, "_a"}; qa.push_back(e);
    e.chk = cb; e.exp = xb; e.name = {nm, "_b"}; qb.push_back(e);
  endtask

  function automatic logic [DW-1:0] sdata(input int k);
    return {8'h5A, 8'(k), 16'hBEEF, 16'(k * 3 + 1)};
  endfunction

  localparam logic [DW-1:0] V5    = 48'h1234_5678_9ABC;
  localparam logic [DW-1:0] VA    = 48'hA5A5_0000_0001;
  localparam logic [DW-1:0] V0    = 48'h0F0F_0000_0000;
  localparam logic [DW-1:0] VTOP  = 48'hFFFF_0000_03FF;
  localparam logic [DW-1:0] V222  = 48'h2222_2222_2222;
  localparam logic [DW-1:0] V111  = 48'h1111_1111_1111;
  localparam logic [DW-1:0] V333  = 48'h3333_3333_3333;
  localparam logic [DW-1:0] VAAAA = 48'h0000_0000_AAAA;
  localparam logic [DW-1:0] VBBBB = 48'h0000_0000_BBBB;
  localparam logic [DW-1:0] Z     = '0;

`ifdef TDP_RAM_WRITE_THROUGH_EN
  localparam logic [DW-1:0] COL_B  = V111;  // B reading while A writes 9
  localparam logic [DW-1:0] COL_AW = V111;  // A's own write-cycle output
  localparam logic [DW-1:0] COL_A  = V333;  // A reading while B writes 9
`else
  localparam logic [DW-1:0] COL_B  = V222;
  localparam logic [DW-1:0] COL_AW = V222;
  localparam logic [DW-1:0] COL_A  = V111;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check("por_a", a_data_out, Z);
    check("por_b", b_data_out, Z);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Load mem[5], read it on both ports so outputs become nonzero.
    cyc(1, 0, 10'd5, V5, 0, Z, 0, 1, 10'd0, Z, 0, Z, "w5");
    cyc(1, 1, 10'd5, Z,  1, V5, 1, 1, 10'd5, Z, 1, V5, "r5");

    // Asynchronous reset mid-cycle while a write to 5 is presented: must be dropped.
    cyc(1, 0, 10'd5, 48'hDEAD_DEAD_DEAD, 0, Z, 1, 1, 10'd5, Z, 0, Z, "rstw");
    #2 rst = 1'b1;
    #1;
    check("async_rst_a", a_data_out, Z);
    check("async_rst_b", b_data_out, Z);
    @(negedge clk);
    check("rst_hold_b", b_data_out, Z);
    drive(0, 1, 10'd0, Z, 0, 1, 10'd0, Z);
    rst = 1'b0;
    cyc(0, 1, 10'd0, Z, 0, Z, 1, 1, 10'd5, Z, 1, V5, "after_rst5");

    // Basic write via A, read via B, including both address extremes.
    cyc(1, 0, 10'd3,    VA,   0, Z, 0, 1, 10'd0,    Z, 0, Z,    "w3");
    cyc(0, 1, 10'd0,    Z,    0, Z, 1, 1, 10'd3,    Z, 1, VA,   "r3");
    cyc(1, 0, 10'd0,    V0,   0, Z, 0, 1, 10'd0,    Z, 0, Z,    "w0");
    cyc(0, 1, 10'd0,    Z,    0, Z, 1, 1, 10'd0,    Z, 1, V0,   "r0");
    cyc(1, 0, 10'd1023, VTOP, 0, Z, 0, 1, 10'd0,    Z, 0, Z,    "w1023");
    cyc(0, 1, 10'd0,    Z,    0, Z, 1, 1, 10'd1023, Z, 1, VTOP, "r1023");

    // Idle hold: B output must not follow address changes while deselected.
    cyc(0, 1, 10'd0, Z, 0, Z, 1, 1, 10'd3, Z, 1, VA, "r3b");
    for (int unsigned i = 0; i < 4; i++)
      cyc(0, 1, 10'd0, Z, 0, Z, 0, 1, 10'd7, Z, 1, VA, "hold");

    // A writes while B reads the same word.
    cyc(1, 0, 10'd9, V222, 0, Z,      0, 1, 10'd0, Z, 0, Z,     "w9old");
    cyc(1, 0, 10'd9, V111, 1, COL_AW, 1, 1, 10'd9, Z, 1, COL_B, "col_awbr");
    cyc(0, 1, 10'd0, Z,    0, Z,      1, 1, 10'd9, Z, 1, V111,  "r9new");

    // B writes while A reads the same word.
    cyc(1, 1, 10'd9, Z, 1, COL_A, 1, 0, 10'd9, V333, 0, Z, "col_bwar");
    cyc(1, 1, 10'd9, Z, 1, V333,  0, 1, 10'd0, Z,    0, Z, "r9b");

    // Both write the same word: A wins; then both read it.
    cyc(1, 0, 10'd20, VAAAA, 0, Z,     1, 0, 10'd20, VBBBB, 0, Z,     "dualw");
    cyc(1, 1, 10'd20, Z,     1, VAAAA, 1, 1, 10'd20, Z,     1, VAAAA, "r20");

    // Streaming: A writes 0..15, B reads two cycles behind.
    for (int unsigned k = 0; k < 18; k++) begin
      if (k < 16 && k >= 2)
        cyc(1, 0, AW'(k), sdata(int'(k)), 0, Z, 1, 1, AW'(k - 2), Z, 1, sdata(int'(k) - 2), "stream");
      else if (k < 16)
        cyc(1, 0, AW'(k), sdata(int'(k)), 0, Z, 0, 1, 10'd0, Z, 0, Z, "stream");
      else
        cyc(0, 1, 10'd0, Z, 0, Z, 1, 1, AW'(k - 2), Z, 1, sdata(int'(k) - 2), "stream");
    end

    cyc(0, 1, 10'd0, Z, 0, Z, 0, 1, 10'd0, Z, 0, Z, "drain");
    @(negedge clk);
    @(negedge clk);
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", qa.size() + qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
